// File: rtl/dataint_crc_stream_ctrl_if.sv
// Stream-in / result-out bundle for the CRC frame sequencer.
// The master side produces beats and consumes results; the slave side is the sequencer.
interface dataint_crc_stream_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CRC_WIDTH  = 64,
    parameter int CNT_WIDTH  = 16,
    parameter int CHUNKS     = DATA_WIDTH / 8,
    parameter int BW         = $clog2(CHUNKS) + 1
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic [BW-1:0]         s_bytes;

    logic                  o_res_valid;
    logic                  i_res_ready;
    logic [CRC_WIDTH-1:0]  o_res_crc;
    logic [CNT_WIDTH-1:0]  o_res_beats;

    modport master (
        output s_valid, s_data, s_last, s_bytes, i_res_ready,
        input  s_ready, o_res_valid, o_res_crc, o_res_beats
    );

    modport slave (
        input  s_valid, s_data, s_last, s_bytes, i_res_ready,
        output s_ready, o_res_valid, o_res_crc, o_res_beats
    );
endinterface

// File: rtl/dataint_crc_stream_ctrl.sv
// Frame sequencer for the dataint_crc engine: feeds stream beats into the engine
// through a register stage, waits out the engine latency, then presents the CRC
// and beat count on a valid/ready result port. One frame in flight at a time.
module dataint_crc_stream_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int CHUNKS     = DATA_WIDTH / 8,
    parameter int CRC_WIDTH  = 64,
    parameter int CNT_WIDTH  = 16,
    parameter int BW         = $clog2(CHUNKS) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    dataint_crc_stream_ctrl_if.slave bus,
    output logic                  o_load_crc_start,
    output logic                  o_load_from_cascade,
    output logic [CHUNKS-1:0]     o_cascade_sel,
    output logic [DATA_WIDTH-1:0] o_crc_data,
    input  logic [CRC_WIDTH-1:0]  i_crc,
    output logic                  o_len_err,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t                state_q,     state_d;
    logic                  start_q,     start_d;
    logic                  lfc_q,       lfc_d;
    logic [CHUNKS-1:0]     sel_q,       sel_d;
    logic [DATA_WIDTH-1:0] data_q,      data_d;
    logic [CNT_WIDTH-1:0]  beats_q,     beats_d;
    logic [1:0]            drain_q,     drain_d;
    logic                  res_valid_q, res_valid_d;
    logic [CRC_WIDTH-1:0]  res_crc_q,   res_crc_d;
    logic [CNT_WIDTH-1:0]  res_beats_q, res_beats_d;
    logic                  len_err_q,   len_err_d;

    logic                  s_ready_s;
    logic                  accept_s;
    logic                  len_bad_s;
    logic [BW-1:0]         sel_idx_s;
    logic [CHUNKS-1:0]     sel_onehot_s;

    // Ready is withdrawn combinationally in a flush cycle so no beat slips in.
    assign s_ready_s = (state_q == ST_RUN) && !i_flush;
    assign accept_s  = bus.s_valid && s_ready_s;

    // Pick the cascade lane: full beat unless this is a legal short last beat.
    always_comb begin
        len_bad_s = (bus.s_bytes == {BW{1'b0}}) || (bus.s_bytes > BW'(CHUNKS));
        if (bus.s_last && !len_bad_s) begin
            sel_idx_s = bus.s_bytes - {{(BW-1){1'b0}}, 1'b1};
        end else begin
            sel_idx_s = BW'(CHUNKS - 1);
        end
        for (int k = 0; k < CHUNKS; k++) begin
            sel_onehot_s[k] = (sel_idx_s == BW'(k));
        end
    end

    // Next-state and registered-output logic; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        start_d     = 1'b0;
        lfc_d       = 1'b0;
        sel_d       = {CHUNKS{1'b0}};
        data_d      = data_q;
        beats_d     = beats_q;
        drain_d     = drain_q;
        res_valid_d = res_valid_q;
        res_crc_d   = res_crc_q;
        res_beats_d = res_beats_q;
        len_err_d   = 1'b0;

        if (i_flush) begin
            state_d     = ST_IDLE;
            beats_d     = {CNT_WIDTH{1'b0}};
            drain_d     = 2'd0;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    beats_d = {CNT_WIDTH{1'b0}};
                    drain_d = 2'd0;
                    if (bus.s_valid) begin
                        state_d = ST_RUN;
                        start_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        data_d    = bus.s_data;
                        lfc_d     = 1'b1;
                        sel_d     = sel_onehot_s;
                        len_err_d = bus.s_last && len_bad_s;
                        if (beats_q != {CNT_WIDTH{1'b1}}) begin
                            beats_d = beats_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        end else begin
                            beats_d = beats_q;
                        end
                        if (bus.s_last) begin
                            state_d = ST_DRAIN;
                            drain_d = 2'd0;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    // Third drain cycle is the first where i_crc holds the last beat.
                    if (drain_q == 2'd2) begin
                        res_crc_d   = i_crc;
                        res_beats_d = beats_q;
                        res_valid_d = 1'b1;
                        drain_d     = 2'd0;
                        state_d     = ST_RESULT;
                    end else begin
                        drain_d = drain_q + 2'd1;
                        state_d = ST_DRAIN;
                    end
                end
                ST_RESULT: begin
                    if (bus.i_res_ready) begin
                        res_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_RESULT;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output register bank.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            lfc_q       <= 1'b0;
            sel_q       <= {CHUNKS{1'b0}};
            data_q      <= {DATA_WIDTH{1'b0}};
            beats_q     <= {CNT_WIDTH{1'b0}};
            drain_q     <= 2'd0;
            res_valid_q <= 1'b0;
            res_crc_q   <= {CRC_WIDTH{1'b0}};
            res_beats_q <= {CNT_WIDTH{1'b0}};
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            lfc_q       <= lfc_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            beats_q     <= beats_d;
            drain_q     <= drain_d;
            res_valid_q <= res_valid_d;
            res_crc_q   <= res_crc_d;
            res_beats_q <= res_beats_d;
            len_err_q   <= len_err_d;
        end
    end

    assign bus.s_ready         = s_ready_s;
    assign bus.o_res_valid     = res_valid_q;
    assign bus.o_res_crc       = res_crc_q;
    assign bus.o_res_beats     = res_beats_q;
    assign o_load_crc_start    = start_q;
    assign o_load_from_cascade = lfc_q;
    assign o_cascade_sel       = sel_q;
    assign o_crc_data          = data_q;
    assign o_len_err           = len_err_q;
    assign o_busy              = (state_q != ST_IDLE);

endmodule
